// File: rtl/eprom_socket_responder_if.sv
// Board-side view of a 27C64-style ROM socket plus the runtime image load stream.
// The device uses the slave modport; the board or bench drives through master.
interface eprom_socket_responder_if #(
    parameter int unsigned ADDR_WIDTH = 13,
    parameter int unsigned DATA_WIDTH = 8
);
    logic                  ce_n;
    logic                  oe_n;
    logic [ADDR_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] d;
    logic                  d_oe;
    logic                  data_valid;
    logic                  load_start;
    logic                  load_valid;
    logic [DATA_WIDTH-1:0] load_data;
    logic                  load_ready;
    logic                  load_done;

    modport slave (
        input  ce_n, oe_n, a, load_start, load_valid, load_data,
        output d, d_oe, data_valid, load_ready, load_done
    );

    modport master (
        output ce_n, oe_n, a, load_start, load_valid, load_data,
        input  d, d_oe, data_valid, load_ready, load_done
    );
endinterface

// File: rtl/eprom_socket_responder.sv
// Device side of a ROM socket: serves bytes from an internal RAM with programmable
// access, output-enable and float timing; the image can be reloaded as a byte stream.
module eprom_socket_responder #(
    parameter int unsigned           ADDR_WIDTH = 13,
    parameter int unsigned           DATA_WIDTH = 8,
    parameter int unsigned           T_ACC      = 3,
    parameter int unsigned           T_OE       = 1,
    parameter int unsigned           T_DF       = 1,
    parameter logic [DATA_WIDTH-1:0] FILL       = DATA_WIDTH'(8'hFF),
    parameter string                 INIT_FILE  = ""
) (
    input logic                     clk_14M,
    input logic                     reset_n,
    eprom_socket_responder_if.slave bus
);
    localparam int unsigned DEPTH = 1 << ADDR_WIDTH;
    localparam int unsigned CW    = 4;

    typedef enum logic [0:0] {S_SERVE, S_LOAD} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] a_q;
    logic [ADDR_WIDTH-1:0] load_addr_q;
    logic [CW-1:0]         acc_q, acc_d;
    logic [CW-1:0]         oe_q, oe_d;
    logic [CW-1:0]         df_q;
    logic [DATA_WIDTH-1:0] d_q;
    logic                  d_oe_q;
    logic                  valid_q;
    logic                  load_ready_q;
    logic                  load_done_q;
    logic                  addr_restart;
    logic                  sel;
    logic                  ok;

    // Saturating access / output-enable counters and the data-valid decision.
    always_comb begin
        addr_restart = (bus.a != a_q) || bus.ce_n;
        acc_d        = '0;
        oe_d         = '0;
        if (!addr_restart) acc_d = (acc_q == CW'(T_ACC)) ? acc_q : acc_q + CW'(1);
        if (!bus.oe_n && !bus.ce_n) oe_d = (oe_q == CW'(T_OE)) ? oe_q : oe_q + CW'(1);
        sel = !bus.ce_n && !bus.oe_n;
        ok  = sel && (acc_d == CW'(T_ACC)) && (oe_d == CW'(T_OE));
    end

    // Image write port, only active while a load is in progress.
    always_ff @(posedge clk_14M) begin
        if (reset_n && (state_q == S_LOAD) && bus.load_valid && load_ready_q)
            mem[load_addr_q] <= bus.load_data;
    end

    always_ff @(posedge clk_14M) begin
        if (!reset_n) begin
            state_q      <= S_SERVE;
            a_q          <= '0;
            load_addr_q  <= '0;
            acc_q        <= '0;
            oe_q         <= '0;
            df_q         <= '0;
            d_q          <= FILL;
            d_oe_q       <= 1'b0;
            valid_q      <= 1'b0;
            load_ready_q <= 1'b0;
            load_done_q  <= 1'b0;
        end else begin
            load_done_q <= 1'b0;
            case (state_q)
                S_SERVE: begin
                    if (bus.load_start) begin
                        state_q      <= S_LOAD;
                        load_addr_q  <= '0;
                        load_ready_q <= 1'b1;
                        acc_q        <= '0;
                        oe_q         <= '0;
                        df_q         <= '0;
                        d_q          <= FILL;
                        d_oe_q       <= 1'b0;
                        valid_q      <= 1'b0;
                    end else begin
                        acc_q <= acc_d;
                        oe_q  <= oe_d;
                        if (addr_restart) a_q <= bus.a;
                        if (ok) begin
                            d_q     <= mem[a_q];
                            valid_q <= 1'b1;
                            d_oe_q  <= 1'b1;
                            df_q    <= '0;
                        end else if (sel) begin
                            d_q     <= FILL;
                            valid_q <= 1'b0;
                            d_oe_q  <= 1'b1;
                            df_q    <= '0;
                        end else begin
                            // Float window: keep driving the last byte for T_DF edges.
                            valid_q <= 1'b0;
                            if (df_q == CW'(T_DF)) begin
                                d_oe_q <= 1'b0;
                                d_q    <= FILL;
                            end else begin
                                df_q <= df_q + CW'(1);
                            end
                        end
                    end
                end
                S_LOAD: begin
                    if (bus.load_valid && load_ready_q) begin
                        if (load_addr_q == ADDR_WIDTH'(DEPTH - 1)) begin
                            state_q      <= S_SERVE;
                            load_ready_q <= 1'b0;
                            load_done_q  <= 1'b1;
                            acc_q        <= '0;
                            oe_q         <= '0;
                            df_q         <= '0;
                        end else begin
                            load_addr_q <= load_addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
                default: state_q <= S_SERVE;
            endcase
        end
    end

    assign bus.d          = d_q;
    assign bus.d_oe       = d_oe_q;
    assign bus.data_valid = valid_q;
    assign bus.load_ready = load_ready_q;
    assign bus.load_done  = load_done_q;
endmodule
